// File: rtl/alu_pkg.sv
// ALU control codes shared by the ALU control decoder and the execution unit.
// is_illegal() lets producers and consumers agree on which codes are supported.
package alu_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_BNE     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_SLT     = 4'b1101;
    localparam logic [3:0] ALU_SLTU    = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    function automatic logic is_illegal(input logic [3:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB,
            ALU_BNE, ALU_NOR, ALU_SLT, ALU_SLTU: is_illegal = 1'b0;
            default:                             is_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus branch-ready zero, signed overflow
// and illegal-code flags for one control code.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (code)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_ADD: begin
                result = a + b;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB, ALU_BNE: begin
                result = a - b;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  illegal = 1'b1;
        endcase
    end

    // bne inverts the sense so downstream branch logic only ever tests "zero"
    always_comb begin
        if (illegal)
            zero = 1'b0;
        else if (code == ALU_BNE)
            zero = (result != '0);
        else
            zero = (result == '0);
    end

endmodule

// File: rtl/alu_exec.sv
// Two-stage valid/ready execution unit: S1 holds the operation, S2 holds the
// computed result and flags that drive the outputs directly.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cntl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic             s1_valid;
    logic [3:0]       s1_code;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_load;
    logic             in_accept;
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_ovf;
    logic             core_illegal;

    assign s2_load   = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign in_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_accept) begin
            s1_valid <= 1'b1;
            s1_code  <= alu_cntl;
            s1_a     <= a;
            s1_b     <= b;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .code    (s1_code),
        .a       (s1_a),
        .b       (s1_b),
        .result  (core_result),
        .zero    (core_zero),
        .ovf     (core_ovf),
        .illegal (core_illegal)
    );

    // Result registers only change when a real operation moves in, so a
    // stalled output stays stable until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= core_result;
                zero    <= core_zero;
                ovf     <= core_ovf;
                illegal <= core_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            illegal_count <= '0;
        else if (in_accept && is_illegal(alu_cntl) && (illegal_count != '1))
            illegal_count <= illegal_count + 1'b1;
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized traffic
// compared against an arithmetic reference model and an in-order scoreboard.
module tb_alu_exec;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        i;
        int          avail;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       alu_cntl = 4'b0000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mcnt = 0;
    exp_t q[$];
    logic got;
    logic [31:0] last_r;
    logic last_z, last_o, last_i;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_cntl      (alu_cntl),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .ovf           (ovf),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    // Reference ALU in plain signed/unsigned arithmetic
    function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, s;
        sx = $signed(x);
        sy = $signed(y);
        e.r = 32'd0; e.o = 1'b0; e.i = 1'b0; e.avail = 0;
        case (c)
            4'b0000: e.r = x & y;
            4'b0001: e.r = x | y;
            4'b0011: e.r = x ^ y;
            4'b1100: e.r = ~(x | y);
            4'b0010: begin
                s = sx + sy;
                e.r = s[31:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110, 4'b0111: begin
                s = sx - sy;
                e.r = s[31:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1101: e.r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1110: e.r = (x < y) ? 32'd1 : 32'd0;
            default: e.i = 1'b1;
        endcase
        if (e.i)              e.z = 1'b0;
        else if (c == 4'b0111) e.z = (e.r != 0);
        else                  e.z = (e.r == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard step taken on the falling edge, ahead of the next rising edge
    task automatic checkOutput(output logic acc);
        exp_t e;
        cyc++;
        check("in_ready", in_ready, (q.size() < 2) || out_ready);
        check("out_valid", out_valid, (q.size() > 0) && (q[0].avail <= cyc));
        check("illegal_count", illegal_count, mcnt);
        if (out_valid && out_ready) begin
            check("out_has_pending_op", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("result", result, e.r);
                check("zero", zero, e.z);
                check("ovf", ovf, e.o);
                check("illegal", illegal, e.i);
            end
            last_r = result; last_z = zero; last_o = ovf; last_i = illegal;
            got = 1'b1;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e = ref_alu(alu_cntl, a, b);
            e.avail = cyc + 2;
            q.push_back(e);
            if (e.i && mcnt < 255) mcnt++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] x,
                                 input logic [31:0] y, input logic ordy, output logic acc);
        in_valid  = v;
        alu_cntl  = c;
        a         = x;
        b         = y;
        out_ready = ordy;
        @(negedge clk);
        checkOutput(acc);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mcnt = 0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_illegal_count", illegal_count, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, ovf, illegal}, 3'b000);
    endtask

    task automatic runOne(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ez, input logic eo);
        logic acc;
        got = 1'b0;
        applyStimulus(1'b1, c, x, y, 1'b1, acc);
        check({tag, "_accept"}, acc, 1'b1);
        for (int i = 0; i < 10 && !got; i++) applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, acc);
        check({tag, "_timeout"}, got, 1'b1);
        check({tag, "_result"}, last_r, er);
        check({tag, "_zero"}, last_z, ez);
        check({tag, "_ovf"}, last_o, eo);
    endtask

    initial begin
        logic        acc;
        logic [3:0]  codes [4];
        logic [31:0] av [4];
        logic [31:0] bv [4];
        int          idx;
        logic        pend;
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        logic [3:0]  legal [9];

        legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110};

        repeat (2) @(posedge clk);
        #1;
        doReset();

        runOne("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
        runOne("sub_eq", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        runOne("bne_eq", 4'b0111, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
        runOne("bne_ne", 4'b0111, 32'd5, 32'd3, 32'd2, 1'b1, 1'b0);
        runOne("slt", 4'b1101, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        runOne("sltu", 4'b1110, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        runOne("nor", 4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        runOne("sub_ovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);

        // Backpressure: only two ops fit while the consumer stalls
        codes = '{4'b0010, 4'b0110, 4'b0011, 4'b0000};
        for (int i = 0; i < 4; i++) begin av[i] = $urandom; bv[i] = $urandom; end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, codes[idx], av[idx], bv[idx], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, 2);
        for (int i = 0; i < 20 && idx < 4; i++) begin
            applyStimulus(1'b1, codes[idx], av[idx], bv[idx], 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 4);
        for (int i = 0; i < 10 && q.size() != 0; i++) applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, acc);
        check("bp_drained", q.size(), 0);

        // Illegal-code stream drives the counter into saturation
        idx = 0;
        for (int i = 0; i < 300 && idx < 260; i++) begin
            applyStimulus(1'b1, 4'b1111, $urandom, $urandom, 1'b1, acc);
            if (acc) idx++;
        end
        check("ill_accepted", idx, 260);
        for (int i = 0; i < 10 && q.size() != 0; i++) applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, acc);
        check("ill_saturated", illegal_count, 255);
        check("ill_last_result", last_r, 0);
        check("ill_last_flag", last_i, 1'b1);

        // Random traffic with random backpressure; offered op held until taken
        pend = 1'b0; rc = 4'b0000; ra = '0; rb = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                rc = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 8)];
                if ($urandom_range(0, 3) == 0) begin ra = $urandom_range(0, 7); rb = $urandom_range(0, 7); end
                else begin ra = $urandom; rb = $urandom; end
                pend = 1'b1;
            end
            applyStimulus(pend, rc, ra, rb, $urandom_range(0, 2) != 0, acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, acc);
        check("rnd_drained", q.size(), 0);

        // Reset with both stages occupied discards the in-flight work
        applyStimulus(1'b1, 4'b1111, 32'd1, 32'd2, 1'b0, acc);
        applyStimulus(1'b1, 4'b0010, 32'd3, 32'd4, 1'b0, acc);
        check("full_before_reset", in_ready, 1'b0);
        doReset();
        runOne("add_after_reset", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
